decode_stage: RTL and testbench

//  Registered RV32 integer-ALU decode stage; successor to the combinational is_add/is_sub decoder.

---
 rtl/decode_stage.sv | 209 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: RV32 integer-ALU decoder (R-type 0110011 / I-type 0010011) feeding a DEPTH-entry output FIFO.
// Latency: 1 cycle from accept to head of an empty FIFO; sustains one instruction per cycle.
// Backpressure: in_ready = !full (registered, no path from out_ready); flush drops all entries and the same-cycle input.
// Optional build macro DECODE_MEXT_EN: decodes R-type funct7=0000001/funct3=000 as MUL.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [3:0]       out_alu_op,
  output logic             out_use_imm,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
`ifdef DECODE_MEXT_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
`endif

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  entry_t     dec;
  logic       legal;

  entry_t       mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] prev_ptr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;
  entry_t        head;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  // Decode the incoming word; anything unsupported collapses to an all-zero entry with illegal set.
  always_comb begin
    dec   = '0;
    legal = 1'b0;
    dec.rs1 = in_instr[19:15];
    dec.rd  = in_instr[11:7];
    case (opcode)
      7'b0110011: begin
        dec.rs2 = in_instr[24:20];
        case (funct7)
          7'b0000000: begin
            legal = 1'b1;
            case (funct3)
              3'b000:  dec.alu_op = OP_ADD;
              3'b001:  dec.alu_op = OP_SLL;
              3'b010:  dec.alu_op = OP_SLT;
              3'b011:  dec.alu_op = OP_SLTU;
              3'b100:  dec.alu_op = OP_XOR;
              3'b101:  dec.alu_op = OP_SRL;
              3'b110:  dec.alu_op = OP_OR;
              default: dec.alu_op = OP_AND;
            endcase
          end
          7'b0100000: begin
            if (funct3 == 3'b000) begin
              legal = 1'b1;
              dec.alu_op = OP_SUB;
            end else if (funct3 == 3'b101) begin
              legal = 1'b1;
              dec.alu_op = OP_SRA;
            end
          end
`ifdef DECODE_MEXT_EN
          7'b0000001: begin
            if (funct3 == 3'b000) begin
              legal = 1'b1;
              dec.alu_op = OP_MUL;
            end
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        dec.use_imm = 1'b1;
        dec.imm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        legal       = 1'b1;
        case (funct3)
          3'b000: dec.alu_op = OP_ADD;
          3'b010: dec.alu_op = OP_SLT;
          3'b011: dec.alu_op = OP_SLTU;
          3'b100: dec.alu_op = OP_XOR;
          3'b110: dec.alu_op = OP_OR;
          3'b111: dec.alu_op = OP_AND;
          3'b001: begin
            // Shift amounts are a zero-extended 5-bit field, not a signed immediate.
            dec.imm    = {{(XLEN-5){1'b0}}, in_instr[24:20]};
            dec.alu_op = OP_SLL;
            legal      = (funct7 == 7'b0000000);
          end
          default: begin
            dec.imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};
            if (funct7 == 7'b0000000) begin
              dec.alu_op = OP_SRL;
            end else if (funct7 == 7'b0100000) begin
              dec.alu_op = OP_SRA;
            end else begin
              legal = 1'b0;
            end
          end
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // When empty, present the slot behind the read pointer: the last popped entry unless a later push reused it.
  assign prev_ptr = rd_ptr - PW'(1);
  assign head     = out_valid ? mem[rd_ptr] : mem[prev_ptr];

  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_alu_op  = head.alu_op;
  assign out_use_imm = head.use_imm;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;

  // Pointer and occupancy bookkeeping; flush rewinds the write pointer so nothing buffered survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the output fields read zero before the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= dec;
    end
  end

  // Saturating count of accepted illegal instructions; flush does not touch it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (push && dec.illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus a random stream, all results scored against a reference queue.
// Stimulus changes 1 ns after the rising edge; the scoreboard samples on the falling edge.
// Built with DEPTH=2 and CNT_W=2 so full and saturation corners are reached quickly.
module tb_decode_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [3:0]       out_alu_op;
  logic             out_use_imm;
  logic [31:0]      out_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic        use_imm;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   exp_cnt = 0;

  decode_stage #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_alu_op(out_alu_op), .out_use_imm(out_use_imm), .out_imm(out_imm),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // Reference decode, organised by opcode then the {funct7,funct3} pair.
  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    logic ok;
    logic [9:0] key;
    e   = '0;
    ok  = 1'b0;
    key = {i[31:25], i[14:12]};
    if (i[6:0] == 7'h33) begin
      ok = 1'b1;
      case (key)
        {7'h00, 3'd0}: e.op = 4'd0;
        {7'h00, 3'd1}: e.op = 4'd2;
        {7'h00, 3'd2}: e.op = 4'd3;
        {7'h00, 3'd3}: e.op = 4'd4;
        {7'h00, 3'd4}: e.op = 4'd5;
        {7'h00, 3'd5}: e.op = 4'd6;
        {7'h00, 3'd6}: e.op = 4'd8;
        {7'h00, 3'd7}: e.op = 4'd9;
        {7'h20, 3'd0}: e.op = 4'd1;
        {7'h20, 3'd5}: e.op = 4'd7;
`ifdef DECODE_MEXT_EN
        {7'h01, 3'd0}: e.op = 4'd10;
`endif
        default:       ok = 1'b0;
      endcase
      e.rs2 = i[24:20];
    end else if (i[6:0] == 7'h13) begin
      ok    = 1'b1;
      e.imm = {{20{i[31]}}, i[31:20]};
      case (i[14:12])
        3'd0: e.op = 4'd0;
        3'd2: e.op = 4'd3;
        3'd3: e.op = 4'd4;
        3'd4: e.op = 4'd5;
        3'd6: e.op = 4'd8;
        3'd7: e.op = 4'd9;
        3'd1: begin e.op = 4'd2; e.imm = {27'd0, i[24:20]}; ok = (i[31:25] == 7'h00); end
        default: begin
          e.imm = {27'd0, i[24:20]};
          if (i[31:25] == 7'h00) e.op = 4'd6;
          else if (i[31:25] == 7'h20) e.op = 4'd7;
          else ok = 1'b0;
        end
      endcase
      e.use_imm = 1'b1;
    end
    if (ok) begin
      e.rs1 = i[19:15];
      e.rd  = i[11:7];
    end else begin
      e     = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    case ($urandom_range(0, 3))
      0, 1:    opc = 7'h33;
      2:       opc = 7'h13;
      default: opc = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  // Scoreboard: check flags and counter against the model, compare popped heads, then record new pushes.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    logic exp_v;
    logic exp_r;
    if (rst_n === 1'b1) begin
      exp_v = (sb.size() != 0);
      exp_r = (sb.size() < DEPTH);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL sb_out_valid: got %b want %b at %0t", out_valid, exp_v, $time);
      end
      checks++;
      if (in_ready !== exp_r) begin
        errors++;
        $display("FAIL sb_in_ready: got %b want %b at %0t", in_ready, exp_r, $time);
      end
      checks++;
      if (illegal_cnt !== CNT_W'(exp_cnt)) begin
        errors++;
        $display("FAIL sb_illegal_cnt: got %0d want %0d at %0t", illegal_cnt, exp_cnt, $time);
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (exp_v && out_ready) begin
          act.rs1 = out_rs1; act.rs2 = out_rs2; act.rd = out_rd; act.op = out_alu_op;
          act.use_imm = out_use_imm; act.imm = out_imm; act.ill = out_illegal;
          checks++;
          if (act !== sb[0]) begin
            errors++;
            $display("FAIL sb_entry: got %h want %h at %0t", act, sb[0], $time);
          end
          void'(sb.pop_front());
        end
        if (in_valid && exp_r) begin
          e = model(in_instr);
          sb.push_back(e);
          if (e.ill && exp_cnt < CMAX) exp_cnt++;
        end
      end
    end
  end

  // Asynchronous reset discards everything the model holds.
  always @(negedge rst_n) begin
    sb.delete();
    exp_cnt = 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sb.size() == 0) break;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending %0d out_valid %b want 0 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (illegal_cnt !== '0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", illegal_cnt); end
    checks++;
    if ({out_rs1, out_rs2, out_rd, out_alu_op, out_use_imm, out_imm, out_illegal} !== '0) begin
      errors++;
      $display("FAIL rst_fields: got %h want 0", {out_rs1, out_rs2, out_rd, out_alu_op, out_use_imm, out_imm, out_illegal});
    end
    #4 rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_release: got %b want 0", out_valid); end
  endtask

  task automatic test_add();
    in_valid = 1'b1; in_instr = 32'h002081B3; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
    checks++;
    if ({out_rs1, out_rs2, out_rd, out_alu_op, out_use_imm} !== {5'd1, 5'd2, 5'd3, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL add_fields: got rs1 %0d rs2 %0d rd %0d op %0d imm_sel %b want 1 2 3 0 0",
               out_rs1, out_rs2, out_rd, out_alu_op, out_use_imm);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_instr = 32'h402081B3; out_ready = 1'b1;
    step();
    in_instr = 32'hFFF08193;
    checks++; if (out_alu_op !== 4'd1) begin errors++; $display("FAIL b2b_sub: got op %0d want 1", out_alu_op); end
    step();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_alu_op, out_use_imm, out_imm} !== {1'b1, 4'd0, 1'b1, 32'hFFFFFFFF}) begin
      errors++;
      $display("FAIL b2b_addi: got v %b op %0d imm_sel %b imm %h want 1 0 1 ffffffff",
               out_valid, out_alu_op, out_use_imm, out_imm);
    end
    drain();
  endtask

  task automatic test_full();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = {12'h07F, 5'd6, 3'b100, 5'd5, 7'h13};
    step();
    in_instr = {7'h20, 5'd3, 5'd8, 3'b101, 5'd7, 7'h13};
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", in_ready); end
    in_instr = {7'h00, 5'd11, 5'd10, 3'b011, 5'd9, 7'h33};
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_hold: got %b want 0", in_ready); end
    out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_release: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_instr = 32'h00208183; out_ready = 1'b1;
    step();
    in_instr = 32'h022081B3;
    checks++;
    if ({out_illegal, out_rs1, out_rd, out_alu_op, out_imm} !== {1'b1, 5'd0, 5'd0, 4'd0, 32'd0}) begin
      errors++;
      $display("FAIL ill_load: got ill %b rs1 %0d rd %0d op %0d imm %h want 1 0 0 0 0",
               out_illegal, out_rs1, out_rd, out_alu_op, out_imm);
    end
    step();
    in_valid = 1'b0;
`ifdef DECODE_MEXT_EN
    checks++; if (illegal_cnt !== 2'd1) begin errors++; $display("FAIL ill_cnt: got %0d want 1", illegal_cnt); end
    checks++;
    if ({out_illegal, out_alu_op} !== {1'b0, 4'd10}) begin
      errors++; $display("FAIL ill_mul: got ill %b op %0d want 0 10", out_illegal, out_alu_op);
    end
`else
    checks++; if (illegal_cnt !== 2'd2) begin errors++; $display("FAIL ill_cnt: got %0d want 2", illegal_cnt); end
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill_mul: got ill %b want 1", out_illegal); end
`endif
    drain();
  endtask

  task automatic test_flush();
    int c;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3;
    step();
    c = exp_cnt;
    in_instr = 32'h0; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush1_flags: got v %b r %b want 0 1", out_valid, in_ready); end
    checks++; if (illegal_cnt !== CNT_W'(c)) begin errors++; $display("FAIL flush1_cnt: got %0d want %0d", illegal_cnt, c); end
    in_valid = 1'b1; in_instr = 32'h002081B3;
    step();
    in_instr = 32'h402081B3;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_fill: got %b want 0", in_ready); end
    in_instr = 32'h0; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush2_flags: got v %b r %b want 0 1", out_valid, in_ready); end
    checks++; if (illegal_cnt !== CNT_W'(c)) begin errors++; $display("FAIL flush2_cnt: got %0d want %0d", illegal_cnt, c); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL flush_empty: got v %b r %b want 0 1", out_valid, in_ready); end
    in_valid = 1'b1; in_instr = 32'hFFF08193; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_after: got %b want 1", out_valid); end
    drain();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_instr = {20'd0, 5'(k), 7'h03};
      step();
    end
    in_valid = 1'b0;
    checks++; if (illegal_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt: got %0d want 3", illegal_cnt); end
    drain();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3;
    step();
    in_instr = 32'h402081B3;
    step();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, illegal_cnt} !== {1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL async_rst: got v %b r %b cnt %0d want 0 1 0", out_valid, in_ready, illegal_cnt);
    end
    #1 rst_n = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_lost: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      in_instr  = rand_instr();
      step();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_full();
    test_illegal();
    test_flush();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
